dot_accum_progressive: RTL and testbench
========================================

Name: dot_accum_progressive

Overview:
- Downstream consumer of the progressive Q0.15 multiplier.
- Accumulates a vector of VEC_LEN products at one runtime-selected precision (Q1.6, Q1.14 or Q1.30) into a wide signed accumulator.
- Emits the dot product as a saturated Q0.15 word over a valid/ready handshake.
- Used for attention-score dot products where early, low-precision products trade accuracy for latency.

Parameters:
- VEC_LEN, 16, products per dot product (>=1).
- ACC_W, 40, accumulator width in bits (>=32 + clog2(VEC_LEN)).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  begin new dot product; sampled only in IDLE, or in DONE when the result handshake completes.
- prec_sel  in  2  precision select, latched on accepted start: 0=Q1.6, 1=Q1.14, 2=Q1.30, 3=reserved (treated as 2).
- q1_6_in  in  8  Q1.6 product.
- q1_6_valid  in  1  q1_6_in valid.
- q1_14_in  in  16  Q1.14 product.
- q1_14_valid  in  1  q1_14_in valid.
- q1_30_in  in  32  Q1.30 product.
- q1_30_valid  in  1  q1_30_in valid.
- sum_out  out  16  saturated Q0.15 dot product.
- sum_valid  out  1  sum_out valid.
- sum_ready  in  1  downstream accepts sum_out.
- busy  out  1  high in ACCUM or DONE.
- sample_drop  out  1  one-cycle pulse when a selected-stream valid arrives outside ACCUM.

Behaviour:
- Reset: state=IDLE, acc=0, count=0, latched prec=2. Outputs: sum_out=0, sum_valid=0, busy=0, sample_drop=0. Reset mid-operation aborts the vector; no result is produced.
- States: IDLE, ACCUM, DONE.
  - IDLE: start -> ACCUM. On that edge: acc<=0, count<=0, prec latched.
  - ACCUM: each cycle the selected stream's valid is high, add the aligned sample to acc and increment count. Valids on non-selected streams are ignored silently. When the add brings count to VEC_LEN -> DONE on that same edge. start is ignored in ACCUM.
  - DONE: sum_valid=1; sum_out and acc held stable.
    - sum_ready=1 and start=0 -> IDLE.
    - sum_ready=1 and start=1 -> ACCUM directly; acc, count and prec reinitialised. This allows back-to-back vectors.
    - sum_ready=0: stay in DONE indefinitely.
- Alignment to Q.30, sign-extended to ACC_W:
  - Q1.6 sample is sign-extended, then <<24.
  - Q1.14 sample is sign-extended, then <<16.
  - Q1.30 sample is used as-is.
- Output: sum_out is combinational from the acc register.
  - t = acc >>> 15 (arithmetic).
  - Saturate t to [-32768, 32767]: positive overflow gives 0x7FFF, negative gives 0x8000.
- Latency: sum_valid rises in the cycle after the clock edge that accepts the VEC_LEN-th sample.
- Timing: no combinational path from any *_valid input to sum_valid; sum_valid is a decode of the state register.
- sample_drop: pulses, registered, for one cycle when the valid of the latched-precision stream is high while in IDLE or DONE. Such samples are never accumulated. In IDLE, "latched precision" means the value latched at the last start (2 after reset).
- Wrap: count width is clog2(VEC_LEN+1). It never exceeds VEC_LEN.
- Accumulator: acc never wraps for legal inputs because ACC_W provides headroom. Saturation applies only at the output.

Optional Feature:
- Macro DOT_ROUND_EN.
- When defined: round half-up before the shift, t = (acc + 2^14) >>> 15, then saturate.
- When undefined: plain truncation, t = acc >>> 15.
- Nothing else changes: ports, latency and FSM are identical in both builds.

Test Plan:
- Q1.30 nominal: VEC_LEN=4, prec_sel=2, q1_30_in=0x08000000 (0.125) x4, back-to-back valids -> sum_valid one cycle after the 4th sample, sum_out=0x4000.
- Q1.6 path with stray valids: prec_sel=0, q1_6_in=0x08 x4, with q1_30_valid toggling meanwhile -> sum_out=0x4000; the q1_30 samples are ignored.
- Negative saturation: prec_sel=2, q1_30_in=0xC0000000 (-1.0) x4 -> sum_out=0x8000. Then 0x40000000 x4 -> sum_out=0x7FFF.
- Backpressure and back-to-back:
  - Hold sum_ready=0 for 5 cycles in DONE, pulse start and a selected valid -> sum_out stable, start ignored, sample_drop pulses once.
  - Then sum_ready=1 with start=1 -> goes straight to ACCUM; the next vector sums correctly.
- Rounding: VEC_LEN=4, prec_sel=2, products 0x00004000,0,0,0 -> sum_out=0x0000 without DOT_ROUND_EN, 0x0001 with it.
- Reset mid-vector: assert rst_n=0 after 2 of 4 samples -> all outputs 0 immediately, state IDLE. A new start plus 4 samples of 0x08000000 -> 0x4000, with no residue from the aborted vector.

Source files
------------

// File: rtl/dot_accum_progressive_if.sv
// Handshake and sample bus of dot_accum_progressive: start/precision control,
// the three progressive-precision product streams and the result channel.
interface dot_accum_progressive_if;
   logic        start;
   logic [1:0]  prec_sel;
   logic [7:0]  q1_6_in;
   logic        q1_6_valid;
   logic [15:0] q1_14_in;
   logic        q1_14_valid;
   logic [31:0] q1_30_in;
   logic        q1_30_valid;
   logic [15:0] sum_out;
   logic        sum_valid;
   logic        sum_ready;
   logic        busy;
   logic        sample_drop;

   modport master (
      output start, prec_sel,
      output q1_6_in, q1_6_valid, q1_14_in, q1_14_valid, q1_30_in, q1_30_valid,
      output sum_ready,
      input  sum_out, sum_valid, busy, sample_drop
   );

   modport slave (
      input  start, prec_sel,
      input  q1_6_in, q1_6_valid, q1_14_in, q1_14_valid, q1_30_in, q1_30_valid,
      input  sum_ready,
      output sum_out, sum_valid, busy, sample_drop
   );
endinterface

// File: rtl/dot_accum_progressive.sv
// Accumulates VEC_LEN products of one selected precision (aligned to Q.30) and
// emits a saturated Q0.15 dot product. Define DOT_ROUND_EN for round-half-up output.
module dot_accum_progressive #(
   parameter int VEC_LEN = 16,
   parameter int ACC_W   = 40
) (
   input  logic                   clk,
   input  logic                   rst_n,
   dot_accum_progressive_if.slave bus
);

   localparam int CNT_W = $clog2(VEC_LEN + 1);
   localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(VEC_LEN - 1);
   localparam logic signed [ACC_W-1:0] POS_MAX  = ACC_W'(32767);
   localparam logic signed [ACC_W-1:0] NEG_MIN  = -(ACC_W'(32768));
   localparam logic signed [ACC_W-1:0] HALF_LSB = ACC_W'(16384);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t                   state_q, state_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [1:0]               prec_q, prec_d;
   logic                     drop_q, drop_d;

   logic                     sel_valid;
   logic signed [ACC_W-1:0]  sample;
   logic signed [ACC_W-1:0]  t;

   // Stream mux on the latched precision; every stream is aligned to Q.30.
   always_comb begin
      sel_valid = 1'b0;
      sample    = '0;
      case (prec_q)
         2'd0: begin
            sel_valid = bus.q1_6_valid;
            sample    = {{(ACC_W-8){bus.q1_6_in[7]}}, bus.q1_6_in} <<< 24;
         end
         2'd1: begin
            sel_valid = bus.q1_14_valid;
            sample    = {{(ACC_W-16){bus.q1_14_in[15]}}, bus.q1_14_in} <<< 16;
         end
         default: begin
            sel_valid = bus.q1_30_valid;
            sample    = {{(ACC_W-32){bus.q1_30_in[31]}}, bus.q1_30_in};
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      prec_d  = prec_q;
      // Selected-stream samples outside ACCUM are dropped and flagged.
      drop_d  = sel_valid && (state_q != ACCUM);
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = ACCUM;
               acc_d   = '0;
               cnt_d   = '0;
               prec_d  = (bus.prec_sel == 2'd3) ? 2'd2 : bus.prec_sel;
            end
         end
         ACCUM: begin
            if (sel_valid) begin
               acc_d = acc_q + sample;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) state_d = DONE;
            end
         end
         DONE: begin
            if (bus.sum_ready) begin
               if (bus.start) begin
                  state_d = ACCUM;
                  acc_d   = '0;
                  cnt_d   = '0;
                  prec_d  = (bus.prec_sel == 2'd3) ? 2'd2 : bus.prec_sel;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         prec_q  <= 2'd2;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         prec_q  <= prec_d;
         drop_q  <= drop_d;
      end
   end

   // Output conversion is purely combinational from acc_q.
   always_comb begin
`ifdef DOT_ROUND_EN
      t = (acc_q + HALF_LSB) >>> 15;
`else
      t = acc_q >>> 15;
`endif
      if (t > POS_MAX)      bus.sum_out = 16'h7FFF;
      else if (t < NEG_MIN) bus.sum_out = 16'h8000;
      else                  bus.sum_out = t[15:0];
   end

   assign bus.sum_valid   = (state_q == DONE);
   assign bus.busy        = (state_q != IDLE);
   assign bus.sample_drop = drop_q;

endmodule

// File: tb/tb_dot_accum_progressive.sv
// Directed scoreboard bench for dot_accum_progressive (VEC_LEN=4); expected sums
// come from an integer model of alignment, optional rounding and saturation.
module tb_dot_accum_progressive;

   logic clk = 1'b0;
   logic rst_n;
   int   nvec = 0;
   int   nerr = 0;
   logic [15:0] exp_q[$];

   dot_accum_progressive_if dif ();

   dot_accum_progressive #(.VEC_LEN(4), .ACC_W(40)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (dif)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] model(input longint acc);
      longint t;
`ifdef DOT_ROUND_EN
      t = (acc + 64'sd16384) >>> 15;
`else
      t = acc >>> 15;
`endif
      if (t > 32767)  return 16'h7FFF;
      if (t < -32768) return 16'h8000;
      return t[15:0];
   endfunction

   task automatic clear_valids;
      dif.q1_6_valid  = 1'b0;
      dif.q1_14_valid = 1'b0;
      dif.q1_30_valid = 1'b0;
   endtask

   task automatic drive(input int prec, input logic [31:0] v);
      case (prec)
         0:       begin dif.q1_6_in  = v[7:0];  dif.q1_6_valid  = 1'b1; end
         1:       begin dif.q1_14_in = v[15:0]; dif.q1_14_valid = 1'b1; end
         default: begin dif.q1_30_in = v;       dif.q1_30_valid = 1'b1; end
      endcase
   endtask

   // One full vector: start (optionally with the previous result's handshake),
   // four back-to-back samples, then latency and result checks.
   task automatic do_vec(input int prec, input logic [3:0][31:0] s,
                         input bit stray, input bit bb, input string tag);
      longint acc = 0;
      logic [31:0] w;
      for (int i = 0; i < 4; i++) begin
         w = s[i];
         case (prec)
            0:       acc += longint'($signed(w[7:0])) <<< 24;
            1:       acc += longint'($signed(w[15:0])) <<< 16;
            default: acc += longint'($signed(w));
         endcase
      end
      exp_q.push_back(model(acc));
      dif.prec_sel = prec[1:0];
      dif.start    = 1'b1;
      if (bb) dif.sum_ready = 1'b1;
      tick;
      dif.start     = 1'b0;
      dif.sum_ready = 1'b0;
      chk({tag, "_busy"}, {31'd0, dif.busy}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         clear_valids;
         drive(prec, s[i]);
         if (stray) begin
            dif.q1_30_in    = 32'h4000_0000;
            dif.q1_30_valid = (i % 2 == 0);
         end
         tick;
         if (i == 2) chk({tag, "_early_valid"}, {31'd0, dif.sum_valid}, 32'd0);
      end
      clear_valids;
      chk({tag, "_latency"}, {31'd0, dif.sum_valid}, 32'd1);
      chk({tag, "_sum"}, {16'd0, dif.sum_out}, {16'd0, exp_q.pop_front()});
      if (stray) chk({tag, "_nodrop"}, {31'd0, dif.sample_drop}, 32'd0);
   endtask

   task automatic ack(input string tag);
      dif.sum_ready = 1'b1;
      tick;
      dif.sum_ready = 1'b0;
      chk({tag, "_ack_valid"}, {31'd0, dif.sum_valid}, 32'd0);
      chk({tag, "_ack_busy"}, {31'd0, dif.busy}, 32'd0);
   endtask

   initial begin
      rst_n         = 1'b0;
      dif.start     = 1'b0;
      dif.prec_sel  = 2'd0;
      dif.q1_6_in   = '0;
      dif.q1_14_in  = '0;
      dif.q1_30_in  = '0;
      dif.sum_ready = 1'b0;
      clear_valids;
      #12;
      chk("rst_sum", {16'd0, dif.sum_out}, 32'd0);
      chk("rst_valid", {31'd0, dif.sum_valid}, 32'd0);
      chk("rst_busy", {31'd0, dif.busy}, 32'd0);
      chk("rst_drop", {31'd0, dif.sample_drop}, 32'd0);
      rst_n = 1'b1;
      tick;

      do_vec(2, {4{32'h0800_0000}}, 1'b0, 1'b0, "q130");
      ack("q130");
      do_vec(0, {4{32'h0000_0008}}, 1'b1, 1'b0, "q16_stray");
      ack("q16_stray");
      do_vec(2, {4{32'hC000_0000}}, 1'b0, 1'b0, "neg_sat");
      ack("neg_sat");
      do_vec(2, {4{32'h4000_0000}}, 1'b0, 1'b0, "pos_sat");
      ack("pos_sat");
      do_vec(1, {32'h0000_0100, 32'h0000_2000, 32'h0000_F000, 32'h0000_1000},
             1'b0, 1'b0, "q114");
      ack("q114");
      do_vec(3, {4{32'h0800_0000}}, 1'b0, 1'b0, "prec3");
      ack("prec3");

      // Backpressure: result held, start and a selected sample in DONE are dropped.
      do_vec(2, {4{32'h0400_0000}}, 1'b0, 1'b0, "bp");
      tick;
      tick;
      chk("bp_hold1", {16'd0, dif.sum_out}, 32'h2000);
      dif.start       = 1'b1;
      dif.q1_30_in    = 32'h4000_0000;
      dif.q1_30_valid = 1'b1;
      tick;
      dif.start = 1'b0;
      clear_valids;
      chk("bp_drop", {31'd0, dif.sample_drop}, 32'd1);
      chk("bp_still_valid", {31'd0, dif.sum_valid}, 32'd1);
      tick;
      chk("bp_drop_once", {31'd0, dif.sample_drop}, 32'd0);
      chk("bp_hold2", {16'd0, dif.sum_out}, 32'h2000);
      tick;
      do_vec(2, {32'h0100_0000, 32'hF800_0000, 32'h0800_0000, 32'h0800_0000},
             1'b0, 1'b1, "b2b");
      ack("b2b");

      do_vec(2, {32'h0, 32'h0, 32'h0, 32'h0000_4000}, 1'b0, 1'b0, "round");
      ack("round");

      // Reset mid-vector at Q1.6, then confirm precision is back to Q1.30.
      dif.prec_sel = 2'd0;
      dif.start    = 1'b1;
      tick;
      dif.start = 1'b0;
      drive(0, 32'h40);
      tick;
      tick;
      clear_valids;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_sum", {16'd0, dif.sum_out}, 32'd0);
      chk("mid_rst_busy", {31'd0, dif.busy}, 32'd0);
      chk("mid_rst_valid", {31'd0, dif.sum_valid}, 32'd0);
      rst_n = 1'b1;
      tick;
      drive(0, 32'h40);
      tick;
      clear_valids;
      chk("idle_q16_nodrop", {31'd0, dif.sample_drop}, 32'd0);
      drive(2, 32'h0800_0000);
      tick;
      clear_valids;
      chk("idle_q130_drop", {31'd0, dif.sample_drop}, 32'd1);
      do_vec(2, {4{32'h0800_0000}}, 1'b0, 1'b0, "post_rst");
      ack("post_rst");

      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
